mem_ctrl: RTL and testbench
===========================

Name: mem_ctrl

Overview:
Byte-serial memory controller sitting directly below the cpu pipeline. It arbitrates between the instruction-fetch port (IF) and the data port (MEM stage: loads and stores) for the single 8-bit RAM/IO bus (mem_din, mem_dout, mem_a, mem_wr). It assembles or splits 1-, 2- and 4-byte little-endian transfers, honours rdy_in stall, and holds UART writes while io_buffer_full is high.

Parameters:
ADDR_W, 32, width of request addresses and of mem_a
IO_SEL, 2'b11, value of addr[17:16] that marks an IO access

Ports:
clk_in  input  1  system clock; all state on rising edge
rst_in  input  1  asynchronous, active-low reset
rdy_in  input  1  global ready; low freezes the block
if_req  input  1  fetch request; level, held until if_done
if_addr  input  ADDR_W  fetch address (4-byte read)
if_flush  input  1  pipeline flush; cancels any fetch
if_done  output  1  one-cycle pulse; if_inst valid
if_inst  output  32  fetched word
dc_req  input  1  data request; level, held until dc_done
dc_we  input  1  1 = store, 0 = load
dc_size  input  2  0 = 1 byte, 1 = 2 bytes, 2 = 4 bytes; 3 is illegal and treated as 4 bytes
dc_addr  input  ADDR_W  data address
dc_wdata  input  32  store data; low bytes used first
dc_done  output  1  one-cycle pulse; load data or store complete
dc_rdata  output  32  load data, zero-extended (MEM stage sign-extends)
mem_din  input  8  RAM/IO read byte
mem_dout  output  8  RAM/IO write byte
mem_a  output  ADDR_W  byte address
mem_wr  output  1  1 = write
io_buffer_full  input  1  UART TX buffer full

Behaviour:
- Reset (rst_in low, at any time including mid-transfer): go to IDLE and abort the transfer. All outputs are 0. Nothing is written after reset asserts.
- States: IDLE, READ, WRITE, IOWAIT.
- IDLE, no request: mem_a = 0, mem_wr = 0, mem_dout = 0.
- Arbitration at the IDLE edge: dc_req beats if_req.
  - An if_req sampled on the same edge as if_flush is ignored.
  - There is no preemption once a transfer is accepted.
- Call the acceptance edge E0; E_k is the k-th edge after it.
- All bus outputs are registered. Byte i (0..N-1) is presented on mem_a = addr+i during the cycle following E_i.
- READ: mem_din for byte i is sampled at E_{i+2} into bits [8i+7:8i]. Unused upper bytes are 0.
  - done is registered at E_{N+1} and is high for exactly the cycle after E_{N+1}.
  - The FSM re-enters IDLE at E_{N+1}. A new request can be accepted at E_{N+2}.
  - 4-byte read: 6 edges from acceptance to done-cycle start.
- WRITE: mem_wr = 1, mem_dout = wdata byte i, during the cycle after E_i.
  - dc_done is high in the same cycle as the last byte. IDLE is reached at E_N.
- IOWAIT: applies to a store whose addr[17:16] == IO_SEL.
  - While io_buffer_full is high, before any byte is driven, hold mem_wr = 0 and mem_a = addr.
  - Proceed to WRITE on the first edge where io_buffer_full is low. The full check is made only before byte 0.
- rdy_in low: every register holds, including counter, state, outputs and assembled data.
  - mem_wr is combinationally forced to 0 while rdy_in is low; the pending byte is re-presented when rdy_in returns.
  - done pulses are extended for as long as rdy_in is low.
- if_flush high during an IF READ: abort at the next edge, return to IDLE, and do not pulse if_done.
  - if_flush has no effect on a data transfer. A fetch queued behind it is dropped; IF reissues.
- if_inst and dc_rdata hold their last value between done pulses.
- Address arithmetic: addr+i wraps modulo 2^ADDR_W. No alignment is required.

Test Plan:
1. After reset, if_req=1, if_addr=0x100, RAM[0x100..0x103]=13 00 00 00 -> mem_a steps through 0x100..0x103. if_done pulses once, 6 edges after acceptance, with if_inst=0x00000013. mem_wr stays 0 throughout.
2. dc_req store, size=2, addr=0x2000, wdata=0xDEADBEEF -> mem_wr=1 for 4 consecutive cycles with bytes EF BE AD DE at 0x2000..0x2003. dc_done coincides with byte DE.
3. if_req and dc_req (load, size=0, addr=0x40, RAM=0x9C) asserted on the same edge -> the data load is served first with dc_rdata=0x0000009C. The fetch is served afterwards.
4. Store of 1 byte 0x41 to 0x30000 with io_buffer_full=1 for 5 cycles -> mem_wr=0 during the wait. Exactly one write of 0x41 occurs after io_buffer_full falls.
5. rdy_in=0 for 3 cycles in the middle of a 4-byte read -> mem_a frozen and mem_wr=0. The result word and total cycle count equal the unstalled case plus 3.
6. if_flush pulsed during fetch byte 2; also rst_in pulsed low during a store -> no if_done, IDLE on the next edge. The reset drives all outputs to 0 immediately, and no further bytes are written.

Source files
------------

// File: rtl/mem_ctrl_if.sv
// Purpose: CPU-side request ports (IF fetch, MEM data) and the byte-wide RAM/IO bus of mem_ctrl.
// Latency: none (wiring only).
// Backpressure: none here; stalls come from the global rdy_in and from io_buffer_full.
// Ports: if_* = fetch port, dc_* = data port, mem_* = RAM/IO bus, io_buffer_full = UART TX full.
interface mem_ctrl_if #(
  parameter int ADDR_W = 32
);
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_flush;
  logic              if_done;
  logic [31:0]       if_inst;

  logic              dc_req;
  logic              dc_we;
  logic [1:0]        dc_size;
  logic [ADDR_W-1:0] dc_addr;
  logic [31:0]       dc_wdata;
  logic              dc_done;
  logic [31:0]       dc_rdata;

  logic [7:0]        mem_din;
  logic [7:0]        mem_dout;
  logic [ADDR_W-1:0] mem_a;
  logic              mem_wr;
  logic              io_buffer_full;

  // Controller side.
  modport slave (
    input  if_req, if_addr, if_flush,
    output if_done, if_inst,
    input  dc_req, dc_we, dc_size, dc_addr, dc_wdata,
    output dc_done, dc_rdata,
    input  mem_din, io_buffer_full,
    output mem_dout, mem_a, mem_wr
  );

  // Pipeline / memory side.
  modport master (
    output if_req, if_addr, if_flush,
    input  if_done, if_inst,
    output dc_req, dc_we, dc_size, dc_addr, dc_wdata,
    input  dc_done, dc_rdata,
    output mem_din, io_buffer_full,
    input  mem_dout, mem_a, mem_wr
  );
endinterface

// File: rtl/mem_ctrl.sv
// Purpose: arbitrates IF fetch vs MEM load/store onto one 8-bit RAM/IO bus, assembling/splitting LE words.
// Latency: N-byte read -> done registered N+1 edges after acceptance; N-byte write -> done with last byte.
// Backpressure: rdy_in low freezes all state (mem_wr gated off); IO stores wait in IOWAIT while io_buffer_full.
// Ports: clk_in, rst_in (async, active low), rdy_in (global ready), bus (mem_ctrl_if.slave).
module mem_ctrl #(
  parameter int         ADDR_W = 32,
  parameter logic [1:0] IO_SEL = 2'b11
) (
  input  logic       clk_in,
  input  logic       rst_in,
  input  logic       rdy_in,
  mem_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {S_IDLE, S_READ, S_WRITE, S_IOWAIT} state_e;

  state_e            state_q, state_d;
  logic [2:0]        cnt_q, cnt_d;         // READ/WRITE: index of byte currently on mem_a
  logic [2:0]        nbytes_q, nbytes_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       data_q, data_d;       // read word under assembly
  logic              is_if_q, is_if_d;
  logic [ADDR_W-1:0] mem_a_q, mem_a_d;
  logic [7:0]        mem_dout_q, mem_dout_d;
  logic              mem_wr_q, mem_wr_d;
  logic              if_done_q, if_done_d;
  logic              dc_done_q, dc_done_d;
  logic [31:0]       if_inst_q, if_inst_d;
  logic [31:0]       dc_rdata_q, dc_rdata_d;

  // The RAM keeps clocking while rdy_in is low, so the byte due on the first
  // frozen edge would be overwritten by the time we resume. Capture it there
  // and consume it on the resume edge instead of mem_din.
  logic              stall_q, stall_d;
  logic [7:0]        din_hold_q, din_hold_d;

  logic [2:0]        cnt_nxt;
  logic [2:0]        dc_nbytes;
  logic              dc_is_io;
  logic [7:0]        rd_byte;
  logic [31:0]       rd_word;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    nbytes_d   = nbytes_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    data_d     = data_q;
    is_if_d    = is_if_q;
    mem_a_d    = mem_a_q;
    mem_dout_d = mem_dout_q;
    mem_wr_d   = mem_wr_q;
    if_done_d  = 1'b0;
    dc_done_d  = 1'b0;
    if_inst_d  = if_inst_q;
    dc_rdata_d = dc_rdata_q;

    stall_d    = ~rdy_in;
    din_hold_d = (!rdy_in && !stall_q) ? bus.mem_din : din_hold_q;

    cnt_nxt   = cnt_q + 3'd1;
    dc_nbytes = (bus.dc_size == 2'd0) ? 3'd1 : (bus.dc_size == 2'd1) ? 3'd2 : 3'd4;
    dc_is_io  = (bus.dc_addr[17:16] == IO_SEL);
    rd_byte   = stall_q ? din_hold_q : bus.mem_din;
    // Byte cnt_q-1 arrives two edges after it was addressed.
    rd_word   = data_q | ({24'd0, rd_byte} << {cnt_q[1:0] - 2'd1, 3'b000});

    case (state_q)
      S_IDLE: begin
        mem_a_d    = '0;
        mem_wr_d   = 1'b0;
        mem_dout_d = 8'd0;
        cnt_d      = 3'd0;
        if (bus.dc_req) begin
          addr_d   = bus.dc_addr;
          wdata_d  = bus.dc_wdata;
          nbytes_d = dc_nbytes;
          is_if_d  = 1'b0;
          data_d   = 32'd0;
          mem_a_d  = bus.dc_addr;
          if (!bus.dc_we) begin
            state_d = S_READ;
          end else if (dc_is_io && bus.io_buffer_full) begin
            state_d = S_IOWAIT;
          end else begin
            state_d    = S_WRITE;
            mem_wr_d   = 1'b1;
            mem_dout_d = bus.dc_wdata[7:0];
            dc_done_d  = (dc_nbytes == 3'd1);
          end
        end else if (bus.if_req && !bus.if_flush) begin
          addr_d   = bus.if_addr;
          nbytes_d = 3'd4;
          is_if_d  = 1'b1;
          data_d   = 32'd0;
          mem_a_d  = bus.if_addr;
          state_d  = S_READ;
        end
      end

      S_READ: begin
        if (is_if_q && bus.if_flush) begin
          state_d = S_IDLE;
          mem_a_d = '0;
          cnt_d   = 3'd0;
        end else begin
          if (cnt_q != 3'd0) data_d = rd_word;
          if (cnt_q == nbytes_q) begin
            state_d = S_IDLE;
            mem_a_d = '0;
            cnt_d   = 3'd0;
            if (is_if_q) begin
              if_inst_d = rd_word;
              if_done_d = 1'b1;
            end else begin
              dc_rdata_d = rd_word;
              dc_done_d  = 1'b1;
            end
          end else begin
            cnt_d = cnt_nxt;
            // Past the last byte the address just holds until data drains.
            if (cnt_nxt < nbytes_q) mem_a_d = addr_q + ADDR_W'(cnt_nxt);
          end
        end
      end

      S_WRITE: begin
        if (cnt_nxt < nbytes_q) begin
          cnt_d      = cnt_nxt;
          mem_a_d    = addr_q + ADDR_W'(cnt_nxt);
          mem_dout_d = wdata_q[{cnt_nxt[1:0], 3'b000} +: 8];
          mem_wr_d   = 1'b1;
          dc_done_d  = (cnt_nxt == nbytes_q - 3'd1);
        end else begin
          state_d    = S_IDLE;
          cnt_d      = 3'd0;
          mem_a_d    = '0;
          mem_wr_d   = 1'b0;
          mem_dout_d = 8'd0;
        end
      end

      S_IOWAIT: begin
        // Fullness is only checked before byte 0; once going, the store completes.
        if (!bus.io_buffer_full) begin
          state_d    = S_WRITE;
          cnt_d      = 3'd0;
          mem_a_d    = addr_q;
          mem_dout_d = wdata_q[7:0];
          mem_wr_d   = 1'b1;
          dc_done_d  = (nbytes_q == 3'd1);
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q    <= S_IDLE;
      cnt_q      <= 3'd0;
      nbytes_q   <= 3'd0;
      addr_q     <= '0;
      wdata_q    <= 32'd0;
      data_q     <= 32'd0;
      is_if_q    <= 1'b0;
      mem_a_q    <= '0;
      mem_dout_q <= 8'd0;
      mem_wr_q   <= 1'b0;
      if_done_q  <= 1'b0;
      dc_done_q  <= 1'b0;
      if_inst_q  <= 32'd0;
      dc_rdata_q <= 32'd0;
    end else if (rdy_in) begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      nbytes_q   <= nbytes_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      data_q     <= data_d;
      is_if_q    <= is_if_d;
      mem_a_q    <= mem_a_d;
      mem_dout_q <= mem_dout_d;
      mem_wr_q   <= mem_wr_d;
      if_done_q  <= if_done_d;
      dc_done_q  <= dc_done_d;
      if_inst_q  <= if_inst_d;
      dc_rdata_q <= dc_rdata_d;
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      stall_q    <= 1'b0;
      din_hold_q <= 8'd0;
    end else begin
      stall_q    <= stall_d;
      din_hold_q <= din_hold_d;
    end
  end

  assign bus.mem_a    = mem_a_q;
  assign bus.mem_dout = mem_dout_q;
  assign bus.mem_wr   = mem_wr_q & rdy_in;
  assign bus.if_done  = if_done_q;
  assign bus.if_inst  = if_inst_q;
  assign bus.dc_done  = dc_done_q;
  assign bus.dc_rdata = dc_rdata_q;

endmodule

// File: tb/tb_mem_ctrl.sv
// Purpose: self-checking bench for mem_ctrl: vector table, hand-written corner sequences, random traffic vs a byte-array model.
// Latency: bus model RAM returns mem_din one edge after mem_a; writes land on the edge mem_wr is seen.
// Backpressure: bench drives rdy_in stalls and io_buffer_full directly.
module tb_mem_ctrl;

  logic clk_in = 1'b0;
  logic rst_in = 1'b0;
  logic rdy_in = 1'b1;

  mem_ctrl_if #(.ADDR_W(32)) bus ();

  mem_ctrl #(.ADDR_W(32), .IO_SEL(2'b11)) dut (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .rdy_in (rdy_in),
    .bus    (bus)
  );

  always #5 clk_in = ~clk_in;

  logic [7:0]  ram     [0:65535];
  logic [7:0]  ref_mem [0:65535];
  logic [39:0] wlog [$];

  // Bus-side RAM with one cycle read latency; IO-space writes go to the log only.
  always @(posedge clk_in) begin
    bus.mem_din <= ram[bus.mem_a[15:0]];
    if (bus.mem_wr === 1'b1) begin
      wlog.push_back({bus.mem_a, bus.mem_dout});
      if (bus.mem_a[17:16] != 2'b11) ram[bus.mem_a[15:0]] <= bus.mem_dout;
    end
  end

  int n_checks = 0;
  int n_pass   = 0;

  function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endfunction

  function automatic int nbytes(input bit is_if, input logic [1:0] size);
    if (is_if || size >= 2'd2) return 4;
    return (size == 2'd0) ? 1 : 2;
  endfunction

  // One complete request; stall_len cycles of rdy_in low starting at stall_at,
  // and hold extra rdy_in-low cycles once done is seen.
  task automatic run_txn(input string name, input bit is_if, input bit we, input logic [1:0] size,
                         input logic [31:0] addr, input logic [31:0] wdata, input logic [31:0] exp_rdata,
                         input int exp_cycles, input int stall_at, input int stall_len, input int hold);
    int n, cycles, k;
    bit got, trace_ok, done_ok, log_ok;
    logic [31:0] last_a, rdata;
    logic [39:0] exp_entry;
    n = nbytes(is_if, size);
    wlog.delete();
    last_a = bus.mem_a;
    if (is_if) begin
      bus.if_req = 1'b1; bus.if_addr = addr;
    end else begin
      bus.dc_req = 1'b1; bus.dc_we = we; bus.dc_size = size; bus.dc_addr = addr; bus.dc_wdata = wdata;
    end
    cycles = 0; k = 0; got = 1'b0; trace_ok = 1'b1;
    while (!got && cycles < 64) begin
      rdy_in = !(cycles >= stall_at && cycles < stall_at + stall_len);
      @(negedge clk_in);
      cycles++;
      if (!rdy_in) begin
        if (bus.mem_a !== last_a || bus.mem_wr !== 1'b0) trace_ok = 1'b0;
      end else begin
        if (we) begin
          if (k < n && (bus.mem_wr !== 1'b1 || bus.mem_a !== addr + 32'(k) || bus.mem_dout !== wdata[8*k +: 8]))
            trace_ok = 1'b0;
        end else begin
          if (bus.mem_wr !== 1'b0) trace_ok = 1'b0;
          if (k < n && bus.mem_a !== addr + 32'(k)) trace_ok = 1'b0;
        end
        k++;
      end
      last_a = bus.mem_a;
      got = is_if ? bus.if_done : bus.dc_done;
    end
    rdy_in = 1'b1;
    check({name, " done-latency"}, 64'(cycles), 64'(exp_cycles));
    rdata = is_if ? bus.if_inst : bus.dc_rdata;
    done_ok = got;
    for (int h = 0; h < hold; h++) begin
      rdy_in = 1'b0;
      @(negedge clk_in);
      if ((is_if ? bus.if_done : bus.dc_done) !== 1'b1) done_ok = 1'b0;
    end
    rdy_in = 1'b1;
    bus.if_req = 1'b0;
    bus.dc_req = 1'b0;
    @(negedge clk_in);
    if (bus.if_done !== 1'b0 || bus.dc_done !== 1'b0) done_ok = 1'b0;
    check({name, " done-pulse"}, 64'(done_ok), 64'd1);
    check({name, " bus-trace"}, 64'(trace_ok), 64'd1);
    if (we) begin
      log_ok = (wlog.size() == n);
      for (int i = 0; i < n; i++) begin
        exp_entry = {addr + 32'(i), wdata[8*i +: 8]};
        if (i < wlog.size() && wlog[i] !== exp_entry) log_ok = 1'b0;
        ref_mem[exp_entry[23:8]] = exp_entry[7:0];
      end
      check({name, " write-log"}, 64'(log_ok), 64'd1);
    end else begin
      check({name, " rdata"}, 64'(rdata), 64'(exp_rdata));
    end
  endtask

  typedef struct {
    string       name;
    bit          is_if;
    bit          we;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    int          exp_cycles;
  } vec_t;

  vec_t vecs [11];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit          seen, is_if, we;
    int          n, st_at, st_len, hold, exp_cyc;
    logic [1:0]  size;
    logic [31:0] addr, wdata, expd;

    vecs[0]  = '{"fetch 0x100",      1'b1, 1'b0, 2'd2, 32'h0000_0100, 32'h0,         32'h0000_0013, 6};
    vecs[1]  = '{"load b 0x40",      1'b0, 1'b0, 2'd0, 32'h0000_0040, 32'h0,         32'h0000_009C, 3};
    vecs[2]  = '{"load h 0x123",     1'b0, 1'b0, 2'd1, 32'h0000_0123, 32'h0,         32'h0000_2423, 4};
    vecs[3]  = '{"load w 0x201",     1'b0, 1'b0, 2'd2, 32'h0000_0201, 32'h0,         32'h0403_0201, 6};
    vecs[4]  = '{"load sz3 0xabc",   1'b0, 1'b0, 2'd3, 32'h0000_0ABC, 32'h0,         32'hBFBE_BDBC, 6};
    vecs[5]  = '{"load h wrap",      1'b0, 1'b0, 2'd1, 32'hFFFF_FFFF, 32'h0,         32'h0000_00FF, 4};
    vecs[6]  = '{"store w 0x2000",   1'b0, 1'b1, 2'd2, 32'h0000_2000, 32'hDEAD_BEEF, 32'h0,         4};
    vecs[7]  = '{"store b 0x50",     1'b0, 1'b1, 2'd0, 32'h0000_0050, 32'h1234_5677, 32'h0,         1};
    vecs[8]  = '{"store h 0x60",     1'b0, 1'b1, 2'd1, 32'h0000_0060, 32'hCAFE_F00D, 32'h0,         2};
    vecs[9]  = '{"readback 0x2000",  1'b0, 1'b0, 2'd2, 32'h0000_2000, 32'h0,         32'hDEAD_BEEF, 6};
    vecs[10] = '{"fetch 0x201",      1'b1, 1'b0, 2'd2, 32'h0000_0201, 32'h0,         32'h0403_0201, 6};

    for (int i = 0; i < 65536; i++) ram[i] = 8'(i);
    ram[16'h0100] = 8'h13; ram[16'h0101] = 8'h00; ram[16'h0102] = 8'h00; ram[16'h0103] = 8'h00;
    ram[16'h0040] = 8'h9C;
    for (int i = 0; i < 65536; i++) ref_mem[i] = ram[i];

    bus.if_req = 1'b0; bus.if_addr = '0; bus.if_flush = 1'b0;
    bus.dc_req = 1'b0; bus.dc_we = 1'b0; bus.dc_size = 2'd0; bus.dc_addr = '0; bus.dc_wdata = '0;
    bus.io_buffer_full = 1'b0;

    // Reset state.
    repeat (2) @(negedge clk_in);
    check("reset mem_a",    64'(bus.mem_a),    64'd0);
    check("reset mem_wr",   64'(bus.mem_wr),   64'd0);
    check("reset mem_dout", 64'(bus.mem_dout), 64'd0);
    check("reset if_done",  64'(bus.if_done),  64'd0);
    check("reset dc_done",  64'(bus.dc_done),  64'd0);
    check("reset if_inst",  64'(bus.if_inst),  64'd0);
    check("reset dc_rdata", 64'(bus.dc_rdata), 64'd0);
    rst_in = 1'b1;
    @(negedge clk_in);

    for (int v = 0; v < 11; v++)
      run_txn(vecs[v].name, vecs[v].is_if, vecs[v].we, vecs[v].size, vecs[v].addr,
              vecs[v].wdata, vecs[v].exp_rdata, vecs[v].exp_cycles, 99, 0, 0);

    // Data request beats a same-edge fetch.
    bus.if_req = 1'b1; bus.if_addr = 32'h100;
    bus.dc_req = 1'b1; bus.dc_we = 1'b0; bus.dc_size = 2'd0; bus.dc_addr = 32'h40;
    seen = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk_in);
      if (bus.if_done) seen = 1'b1;
      if (bus.dc_done) break;
    end
    check("arb dc_done seen", 64'(bus.dc_done), 64'd1);
    check("arb dc_rdata", 64'(bus.dc_rdata), 64'h9C);
    check("arb fetch not first", 64'(seen), 64'd0);
    bus.dc_req = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk_in);
      if (bus.if_done) break;
    end
    check("arb if_done seen", 64'(bus.if_done), 64'd1);
    check("arb if_inst", 64'(bus.if_inst), 64'h13);
    bus.if_req = 1'b0;
    @(negedge clk_in);

    // IO store held while the UART buffer is full.
    wlog.delete();
    bus.io_buffer_full = 1'b1;
    bus.dc_req = 1'b1; bus.dc_we = 1'b1; bus.dc_size = 2'd0; bus.dc_addr = 32'h0003_0000; bus.dc_wdata = 32'h41;
    seen = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk_in);
      if (bus.mem_wr !== 1'b0 || bus.mem_a !== 32'h0003_0000 || bus.dc_done !== 1'b0) seen = 1'b0;
    end
    check("io wait holds", 64'(seen), 64'd1);
    bus.io_buffer_full = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk_in);
      if (bus.dc_done) break;
    end
    check("io dc_done seen", 64'(bus.dc_done), 64'd1);
    bus.dc_req = 1'b0;
    repeat (3) @(negedge clk_in);
    check("io write count", 64'(wlog.size()), 64'd1);
    check("io write entry", (wlog.size() > 0) ? 64'(wlog[0]) : 64'd0, 64'({32'h0003_0000, 8'h41}));

    // rdy_in stalls: mid-read, mid-write, and stretching a done pulse.
    run_txn("stalled read",  1'b0, 1'b0, 2'd2, 32'h201,  32'h0,         32'h0403_0201, 9, 2, 3, 0);
    run_txn("stalled write", 1'b0, 1'b1, 2'd2, 32'h3000, 32'h1122_3344, 32'h0,         6, 1, 2, 0);
    run_txn("done stretch",  1'b0, 1'b0, 2'd0, 32'h40,   32'h0,         32'h9C,        3, 99, 0, 3);

    // Flush does not touch a data transfer.
    bus.if_flush = 1'b1;
    run_txn("load under flush", 1'b0, 1'b0, 2'd1, 32'h123, 32'h0, 32'h2423, 4, 99, 0, 0);
    bus.if_flush = 1'b0;

    // Flush during fetch byte 2.
    bus.if_req = 1'b1; bus.if_addr = 32'h100;
    repeat (3) @(negedge clk_in);
    check("flush pre addr", 64'(bus.mem_a), 64'h102);
    bus.if_flush = 1'b1;
    @(negedge clk_in);
    check("flush abort mem_a", 64'(bus.mem_a), 64'd0);
    @(negedge clk_in);
    check("flush blocks accept", 64'(bus.mem_a), 64'd0);
    bus.if_req = 1'b0; bus.if_flush = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk_in);
      if (bus.if_done) seen = 1'b1;
    end
    check("flush no if_done", 64'(seen), 64'd0);

    // Reset in the middle of a store.
    wlog.delete();
    bus.dc_req = 1'b1; bus.dc_we = 1'b1; bus.dc_size = 2'd2; bus.dc_addr = 32'h4000; bus.dc_wdata = 32'hA1B2_C3D4;
    repeat (2) @(negedge clk_in);
    rst_in = 1'b0;
    #1;
    check("mid reset mem_wr",   64'(bus.mem_wr),   64'd0);
    check("mid reset mem_a",    64'(bus.mem_a),    64'd0);
    check("mid reset mem_dout", 64'(bus.mem_dout), 64'd0);
    check("mid reset dc_rdata", 64'(bus.dc_rdata), 64'd0);
    bus.dc_req = 1'b0;
    repeat (2) @(negedge clk_in);
    rst_in = 1'b1;
    repeat (6) @(negedge clk_in);
    check("mid reset write count", 64'(wlog.size()), 64'd1);
    check("mid reset byte1 untouched", 64'(ram[16'h4001]), 64'h01);
    ref_mem[16'h4000] = 8'hD4;

    // Random traffic against the byte-array model.
    for (int r = 0; r < 40; r++) begin
      is_if = ($urandom_range(0, 3) == 0);
      we    = !is_if && ($urandom_range(0, 1) == 1);
      size  = 2'($urandom_range(0, 3));
      if (!we && $urandom_range(0, 5) == 0) addr = 32'hFFFF_FFFC + 32'($urandom_range(0, 3));
      else addr = 32'($urandom_range(0, 1023));
      wdata = $urandom;
      n = nbytes(is_if, size);
      expd = 32'd0;
      if (!we) for (int i = 0; i < n; i++) expd = expd | (32'(ref_mem[16'(addr + 32'(i))]) << (8 * i));
      exp_cyc = we ? n : n + 2;
      st_len = 0; st_at = 99;
      if ($urandom_range(0, 2) == 0 && !(we && n == 1)) begin
        st_len = $urandom_range(1, 3);
        st_at  = $urandom_range(1, we ? n - 1 : n);
      end
      exp_cyc = exp_cyc + st_len;
      hold = $urandom_range(0, 2);
      run_txn($sformatf("rand%0d", r), is_if, we, size, addr, wdata, expd, exp_cyc, st_at, st_len, hold);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
